mips_multiciclo: RTL and testbench
==================================

# mips_multiciclo

Parametrised multicycle MIPS-subset core: one shared memory port, an FSM controller and a single ALU reused across cycles. It replaces the single-cycle datapath as the next-generation core. It runs R-type, addi, lw, sw, beq, j and halt, and each instruction takes 3-5 cycles plus memory wait states. A ready/request memory handshake with a wait-state timeout lets slow memories sit behind it.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- ADDR_W, 32, width of mem_addr; byte address truncated to its low ADDR_W bits
- TIMEOUT, 255, max consecutive cycles mem_req may wait for mem_ready; 0 disables timeout
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, sampled when mem_req & mem_ready
- mem_ready  in  1  transfer completes in any cycle where mem_req & mem_ready
- pc_out  out  32  current PC
- retired  out  1  one-cycle pulse on the final cycle of each completed instruction
- halted  out  1  sticky; core stopped
- err  out  1  sticky; stop was caused by a fault

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: mem_req=1, mem_we=0, addr=PC. On ready: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE: A<=R[rs], B<=R[rt], ALUOut<=PC+(sext(imm)<<2), go to EXEC.
- EXEC, by opcode:
  - R-type (0x00): ALUOut<=A op B, go to WB. funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). Any other funct is illegal.
  - addi (0x08): ALUOut<=A+sext(imm), go to WB.
  - lw (0x23) / sw (0x2B): ALUOut<=A+sext(imm). Go to MEM; if ALUOut[1:0]≠0, go to HALT with err=1 and issue no access.
  - beq (0x04): if A==B, PC<=ALUOut. Retire, go to FETCH.
  - j (0x02, under JUMP_EN): PC<={PC[31:28],IR[25:0],2'b00}. Retire, go to FETCH.
  - halt (0x3F): retire, go to HALT with err=0.
  - Any other opcode: go to HALT with err=1, no retire.
- MEM:
  - lw: mem_req=1, we=0, addr=ALUOut. On ready: MDR<=mem_rdata, go to WB.
  - sw: mem_req=1, we=1, wdata=B. On ready: retire, go to FETCH.
- WB: R-type writes ALUOut to rd; addi writes ALUOut to rt; lw writes MDR to rt. Writes to R0 are discarded and R0 always reads 0. Retire, go to FETCH.
- HALT: halted=1, mem_req=0. The core leaves HALT only on reset.
- Arithmetic: all 32-bit, add/sub wrap modulo 2^32, no overflow trap.
- Handshake: while mem_req=1, mem_addr, mem_we and mem_wdata stay stable until completion. mem_ready is ignored while mem_req=0.
- Timeout: a counter counts consecutive mem_req=1 cycles with mem_ready=0. When it reaches TIMEOUT, the next state is HALT with err=1 and the request drops. The counter clears on every completed transfer.

## Timing
- Reset (rst_n low at an edge):
  - State=FETCH, PC=RESET_PC, R1..R31=0, IR/A/B/ALUOut/MDR=0.
  - Outputs during reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, retired=0, halted=0, err=0.
  - First fetch request appears in the first cycle after rst_n goes high.
- Reset mid-transfer abandons the transfer. mem_req is 0 from the next cycle and no register or PC update occurs.
- Cycle counts with zero wait states: beq/j/halt 3, sw 4, R-type/addi 4, lw 5. Each wait state adds 1 cycle to FETCH or MEM.
- Register-file writes in WB are visible to the DECODE of the next instruction. There is no forwarding need.
- retired rises in the last cycle of the instruction and is never high on two consecutive cycles.

## Configuration
- JUMP_EN defined: opcode 0x02 executes j as above.
- JUMP_EN undefined: opcode 0x02 is illegal and goes to HALT with err=1. No jump-target logic is built.

## Test plan
- Reset, then program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; halt with zero wait states. Required: R3=12, halted=1, err=0, 4 retired pulses, 14 cycles from first request to halted.
- Program sw $3,8($0); lw $4,8($0) with mem_ready delayed 3 cycles on every transfer. Required: write at addr 8 with wdata=12, R4=12, and each transfer holds addr/we/wdata stable through its waits.
- Branches: beq $1,$1,+2 and beq $1,$2,+2. Required: PC advances by 12 when taken and by 4 when not taken. With JUMP_EN, j 0x40 gives PC=0x100.
- Faults:
  - lw at address 6: halted=1, err=1, no mem_req issued for the load.
  - Opcode 0x3E: halted=1, err=1.
  - Without JUMP_EN, opcode 0x02: halted=1, err=1.
- Timeout and reset:
  - TIMEOUT=4 with mem_ready held low: HALT and err=1 after 4 waiting cycles.
  - rst_n pulsed low mid-fetch: mem_req=0 next cycle, PC=RESET_PC, flags cleared.

Source files
------------

// File: rtl/mips_multiciclo.sv
// mips_multiciclo: multicycle MIPS-subset core sharing one memory port and one ALU across cycles.
// Build option: define JUMP_EN to decode opcode 0x02 as j; otherwise it is treated as illegal.
// state  | meaning
// FETCH  | read IR at PC, PC += 4
// DECODE | read A/B, precompute branch target
// EXEC   | ALU op, branch/jump resolve, fault detect
// MEM    | lw/sw data transfer at ALUOut
// WB     | register-file write, retire
// HALT   | stopped until reset
module mips_multiciclo #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_out,
    output logic              retired,
    output logic              halted,
    output logic              err
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_HALT  = 6'h3F;
`ifdef JUMP_EN
    localparam logic [5:0] OP_J     = 6'h02;
`endif
    localparam logic [31:0] TMO = 32'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d, wait_q, wait_d;
    logic        err_q, err_d;
    logic [31:0] regs_q [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, addr_sum, addr_c;
    logic        timeout;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
    assign addr_sum = a_q + imm_sext;

    // Down-counter reloads on every non-waiting cycle; terminal count 1 ends a stalled request.
    assign timeout = (TMO != 32'd0) && mem_req && !mem_ready && (wait_q == 32'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            wait_q  <= TMO;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (rf_we && rf_waddr != 5'd0) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        err_d    = err_q;
        wait_d   = (mem_req && !mem_ready) ? wait_q - 32'd1 : TMO;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_q;
        case (state_q)
            S_FETCH: begin
                if (timeout) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else if (mem_req && mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                alu_d   = pc_q + (imm_sext << 2);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE: begin
                        state_d = S_WB;
                        case (funct)
                            6'h20:   alu_d = a_q + b_q;
                            6'h22:   alu_d = a_q - b_q;
                            6'h24:   alu_d = a_q & b_q;
                            6'h25:   alu_d = a_q | b_q;
                            6'h2A:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
                            default: begin
                                state_d = S_HALT;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                    OP_ADDI: begin
                        alu_d   = addr_sum;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d = addr_sum;
                        if (addr_sum[1:0] != 2'b00) begin
                            state_d = S_HALT;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_MEM;
                        end
                    end
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = alu_q;
                        state_d = S_FETCH;
                    end
`ifdef JUMP_EN
                    OP_J: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        state_d = S_FETCH;
                    end
`endif
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (timeout) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else if (mem_req && mem_ready) begin
                    if (opcode == OP_LW) begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                state_d = S_FETCH;
                if (opcode == OP_RTYPE) begin
                    rf_waddr = rd;
                end else if (opcode == OP_LW) begin
                    rf_wdata = mdr_q;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are forced quiet while rst_n is low so a reset abandons any open transfer at once.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_c    = '0;
        mem_wdata = '0;
        retired   = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    addr_c  = pc_q;
                end
                S_EXEC: begin
                    retired = (opcode == OP_BEQ) || (opcode == OP_HALT);
`ifdef JUMP_EN
                    if (opcode == OP_J) retired = 1'b1;
`endif
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    addr_c  = alu_q;
                    if (opcode == OP_SW) begin
                        mem_we    = 1'b1;
                        mem_wdata = b_q;
                        retired   = mem_ready;
                    end
                end
                S_WB:    retired = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem_addr = addr_c[ADDR_W-1:0];
    assign pc_out   = pc_q;
    assign halted   = (state_q == S_HALT);
    assign err      = err_q;

endmodule

// File: tb/tb_mips_multiciclo.sv
// Directed bench for mips_multiciclo: memory responder with programmable wait states plus
// per-test programs checked against hand-computed results.
`define CHK(TAG, OBS, EXP) begin checks++; assert ((OBS) === (EXP)) else begin errors++; $error("FAIL %s: observed=%0h expected=%0h", TAG, OBS, EXP); end end

module tb_mips_multiciclo;
    localparam logic [31:0] RP = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req, mem_we, retired, halted, err;
    logic [31:0] mem_addr, mem_wdata, pc_out;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    mips_multiciclo #(.RESET_PC(RP), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc_out(pc_out),
        .retired(retired), .halted(halted), .err(err)
    );

    int checks = 0, errors = 0;
    logic [31:0] mem  [128];
    logic [31:0] wmem [128];
    bit          wvalid [128];
    int          wait_states = 0;
    bit          hold_ready = 0;

    int cyc = 0, age = 0, first_req = -1, last_ret = -1, ret_cnt = 0, dbl_ret = 0;
    int req_cnt = 0, addr6_cnt = 0, wr_cnt = 0, stab_err = 0;
    logic [31:0] last_waddr = '0, last_wdata = '0;
    logic [31:0] fetch_log [$];
    bit          pend_done = 0, pend_we = 0, held = 0, held_we = 0, prev_ret = 0;
    logic [31:0] pend_addr = '0, pend_wdata = '0, held_addr = '0, held_wdata = '0;

    // Memory responder and monitor; a transfer seen with ready here completes at the next rising edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < 128; i++) wvalid[i] = 0;
            age = 0; first_req = -1; last_ret = -1; ret_cnt = 0; dbl_ret = 0;
            req_cnt = 0; addr6_cnt = 0; wr_cnt = 0; stab_err = 0;
            fetch_log.delete();
            pend_done = 0; held = 0; prev_ret = 0; mem_ready = 0;
        end else begin
            if (pend_done) begin
                if (pend_we) begin
                    wmem[pend_addr[8:2]] = pend_wdata;
                    wvalid[pend_addr[8:2]] = 1;
                    wr_cnt++;
                    last_waddr = pend_addr;
                    last_wdata = pend_wdata;
                end else begin
                    fetch_log.push_back(pend_addr);
                end
                age = 0;
            end
            if (held && mem_req &&
                (mem_addr !== held_addr || mem_we !== held_we || mem_wdata !== held_wdata))
                stab_err++;
            if (mem_req && !hold_ready && age >= wait_states) begin
                mem_ready = 1;
                mem_rdata = wvalid[mem_addr[8:2]] ? wmem[mem_addr[8:2]] : mem[mem_addr[8:2]];
            end else begin
                mem_ready = 0;
            end
            if (mem_req) begin
                age++;
                req_cnt++;
                if (mem_addr == 32'd6) addr6_cnt++;
                if (first_req < 0) first_req = cyc;
            end
            pend_done  = mem_req && mem_ready;
            pend_we    = mem_we;
            pend_addr  = mem_addr;
            pend_wdata = mem_wdata;
            held       = mem_req && !mem_ready;
            held_addr  = mem_addr;
            held_we    = mem_we;
            held_wdata = mem_wdata;
            #1;
            if (retired) begin
                if (prev_ret) dbl_ret++;
                ret_cnt++;
                last_ret = cyc;
            end
            prev_ret = retired;
        end
    end

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    localparam logic [31:0] HALT_I = {6'h3F, 26'd0};

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = '0;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1 rst_n = 0;
        @(posedge clk); #1;
        `CHK({tag, "_rst_req"},    mem_req,   1'b0)
        `CHK({tag, "_rst_we"},     mem_we,    1'b0)
        `CHK({tag, "_rst_addr"},   mem_addr,  32'd0)
        `CHK({tag, "_rst_wdata"},  mem_wdata, 32'd0)
        `CHK({tag, "_rst_ret"},    retired,   1'b0)
        `CHK({tag, "_rst_halted"}, halted,    1'b0)
        `CHK({tag, "_rst_err"},    err,       1'b0)
        `CHK({tag, "_rst_pc"},     pc_out,    RP)
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic wait_halted(input int max_cyc, input string tag);
        int n = 0;
        while (halted !== 1'b1 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        `CHK({tag, "_halted"}, halted, 1'b1)
    endtask

    task automatic load_t1();
        clear_mem();
        mem[RP[8:2]]     = itype(6'h08, 5'd0, 5'd1, 16'd5);
        mem[RP[8:2] + 1] = itype(6'h08, 5'd0, 5'd2, 16'd7);
        mem[RP[8:2] + 2] = rtype(5'd1, 5'd2, 5'd3, 6'h20);
        mem[RP[8:2] + 3] = HALT_I;
    endtask

    initial begin
        // addi/addi/add/halt, zero wait states: 4+4+4+3 cycles, last retire 14 after first request
        load_t1();
        wait_states = 0; hold_ready = 0;
        do_reset("t1");
        wait_halted(100, "t1");
        `CHK("t1_r1", dut.regs_q[1], 32'd5)
        `CHK("t1_r3", dut.regs_q[3], 32'd12)
        `CHK("t1_err", err, 1'b0)
        `CHK("t1_retires", ret_cnt, 4)
        `CHK("t1_cycles", last_ret - first_req, 14)
        `CHK("t1_no_dbl_ret", dbl_ret, 0)

        // store then load through 3 wait states per transfer
        clear_mem();
        mem[RP[8:2]]     = itype(6'h08, 5'd0, 5'd3, 16'd12);
        mem[RP[8:2] + 1] = itype(6'h2B, 5'd0, 5'd3, 16'd8);
        mem[RP[8:2] + 2] = itype(6'h23, 5'd0, 5'd4, 16'd8);
        mem[RP[8:2] + 3] = HALT_I;
        wait_states = 3;
        do_reset("t2");
        wait_halted(200, "t2");
        `CHK("t2_wr_cnt", wr_cnt, 1)
        `CHK("t2_waddr", last_waddr, 32'd8)
        `CHK("t2_wdata", last_wdata, 32'd12)
        `CHK("t2_r4", dut.regs_q[4], 32'd12)
        `CHK("t2_stable", stab_err, 0)
        `CHK("t2_err", err, 1'b0)
        `CHK("t2_cycles", last_ret - first_req, 33)
        `CHK("t2_no_dbl_ret", dbl_ret, 0)

        // taken beq skips two illegal words, untaken beq falls through
        clear_mem();
        mem[RP[8:2]]     = itype(6'h08, 5'd0, 5'd1, 16'd1);
        mem[RP[8:2] + 1] = itype(6'h08, 5'd0, 5'd2, 16'd2);
        mem[RP[8:2] + 2] = itype(6'h04, 5'd1, 5'd1, 16'd2);
        mem[RP[8:2] + 3] = {6'h3E, 26'd0};
        mem[RP[8:2] + 4] = {6'h3E, 26'd0};
        mem[RP[8:2] + 5] = itype(6'h04, 5'd1, 5'd2, 16'd2);
        mem[RP[8:2] + 6] = HALT_I;
        wait_states = 0;
        do_reset("t3");
        wait_halted(100, "t3");
        `CHK("t3_nfetch", fetch_log.size(), 5)
        `CHK("t3_taken", fetch_log[3], RP + 32'd20)
        `CHK("t3_not_taken", fetch_log[4], RP + 32'd24)
        `CHK("t3_pc", pc_out, RP + 32'd28)
        `CHK("t3_err", err, 1'b0)
        `CHK("t3_retires", ret_cnt, 5)

        clear_mem();
        mem[RP[8:2]] = {6'h02, 26'h40};
        mem[64]      = HALT_I;
        do_reset("tj");
        wait_halted(100, "tj");
`ifdef JUMP_EN
        `CHK("tj_target", fetch_log[1], 32'h100)
        `CHK("tj_err", err, 1'b0)
        `CHK("tj_retires", ret_cnt, 2)
`else
        `CHK("tj_err", err, 1'b1)
        `CHK("tj_retires", ret_cnt, 0)
`endif

        // misaligned load: fault without a data request
        clear_mem();
        mem[RP[8:2]] = itype(6'h23, 5'd0, 5'd4, 16'd6);
        do_reset("t4");
        wait_halted(50, "t4");
        `CHK("t4_err", err, 1'b1)
        `CHK("t4_addr6_req", addr6_cnt, 0)
        `CHK("t4_req_cnt", req_cnt, 1)
        `CHK("t4_retires", ret_cnt, 0)

        clear_mem();
        mem[RP[8:2]] = {6'h3E, 26'd0};
        do_reset("t5");
        wait_halted(50, "t5");
        `CHK("t5_err", err, 1'b1)
        `CHK("t5_retires", ret_cnt, 0)

        // TIMEOUT=4 with ready held low: four waiting request cycles, then fault
        hold_ready = 1;
        do_reset("t6");
        wait_halted(50, "t6");
        `CHK("t6_err", err, 1'b1)
        `CHK("t6_req_cycles", req_cnt, 4)
        `CHK("t6_req_dropped", mem_req, 1'b0)

        // reset while the second fetch is stalled
        hold_ready = 0; wait_states = 3;
        load_t1();
        do_reset("t7");
        repeat (8) @(posedge clk);
        #1;
        `CHK("t7_pc_before", pc_out, RP + 32'd4)
        `CHK("t7_req_before", mem_req, 1'b1)
        `CHK("t7_r1_before", dut.regs_q[1], 32'd5)
        rst_n = 0;
        #1;
        `CHK("t7_req_drop", mem_req, 1'b0)
        @(posedge clk); #1;
        `CHK("t7_pc_reset", pc_out, RP)
        `CHK("t7_r1_reset", dut.regs_q[1], 32'd0)
        `CHK("t7_halted", halted, 1'b0)
        `CHK("t7_err", err, 1'b0)
        rst_n = 1;
        #1;
        `CHK("t7_first_req", mem_req, 1'b1)
        wait_halted(200, "t7");
        `CHK("t7_r3", dut.regs_q[3], 32'd12)
        `CHK("t7_err_end", err, 1'b0)

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
